// File: rtl/arb_req_frontend.sv
// rtl/arb_req_frontend.sv - four-channel FIFO requester front-end feeding a round-robin arbiter
// Optional grant checker enabled by defining ARB_REQ_GRANT_CHECK_EN.
module arb_req_frontend #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      wr_en,
    input  logic [4*DW-1:0] wr_data,
    output logic [3:0]      full,
    output logic [3:0]      req,
    input  logic [3:0]      grant,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_ch,
    output logic            grant_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] r_mem  [4][DEPTH];
    logic [AW-1:0] r_wptr [4];
    logic [AW-1:0] r_rptr [4];
    logic [CW-1:0] r_cnt  [4];

    logic [3:0]    w_push;
    logic [3:0]    w_pop;
    logic          w_onehot;
    logic          w_pop_any;
    logic [1:0]    w_pop_ch;
    logic [DW-1:0] w_pop_data;

    always_comb begin
        req  = 4'b0;
        full = 4'b0;
        for (int i = 0; i < 4; i++) begin
            req[i]  = (r_cnt[i] != '0);
            full[i] = (r_cnt[i] == FULL_CNT);
        end
    end

    // A multi-bit grant pops nothing; full is sampled before any same-cycle pop.
    assign w_onehot = (grant != 4'b0) && ((grant & (grant - 4'd1)) == 4'b0);
    assign w_pop    = w_onehot ? (grant & req) : 4'b0;
    assign w_push   = wr_en & ~full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
                if (w_push[i] && !w_pop[i])
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                else if (w_pop[i] && !w_push[i])
                    r_cnt[i] <= r_cnt[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_push[i]) r_mem[i][r_wptr[i]] <= wr_data[i*DW +: DW];
        end
    end

    always_comb begin
        w_pop_any  = 1'b0;
        w_pop_ch   = 2'd0;
        w_pop_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_pop[i]) begin
                w_pop_any  = 1'b1;
                w_pop_ch   = 2'(i);
                w_pop_data = r_mem[i][r_rptr[i]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= 2'd0;
        end else begin
            out_valid <= w_pop_any;
            if (w_pop_any) begin
                out_data <= w_pop_data;
                out_ch   <= w_pop_ch;
            end
        end
    end

`ifdef ARB_REQ_GRANT_CHECK_EN
    logic       r_req_d1;
    logic       r_req_d2;
    logic [3:0] r_grant_d1;
    logic       w_bad;

    // A held grant is legal; only a newly appearing grant needs a recent request.
    assign w_bad = ((grant != 4'b0) && !w_onehot) ||
                   (w_onehot && (grant != r_grant_d1) && !r_req_d1 && !r_req_d2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_d1   <= 1'b0;
            r_req_d2   <= 1'b0;
            r_grant_d1 <= 4'b0;
            grant_err  <= 1'b0;
        end else begin
            r_req_d1   <= |req;
            r_req_d2   <= r_req_d1;
            r_grant_d1 <= grant;
            if (w_bad) grant_err <= 1'b1;
        end
    end
`else
    assign grant_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_req_frontend.sv
// tb/tb_arb_req_frontend.sv - randomized self-checking bench for arb_req_frontend
module tb_arb_req_frontend;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    wr_en;
    logic [4*DW-1:0] wr_data;
    logic [3:0]    full;
    logic [3:0]    req;
    logic [3:0]    grant;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_ch;
    logic          grant_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q [4][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    m_ch;
    logic          m_err;
    logic          m_req1, m_req2;
    logic [3:0]    m_gprev;

    arb_req_frontend #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .req(req), .grant(grant), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_req();
        logic [3:0] r = 4'b0;
        for (int i = 0; i < 4; i++) r[i] = (q[i].size() != 0);
        return r;
    endfunction

    function automatic logic [3:0] m_full();
        logic [3:0] f = 4'b0;
        for (int i = 0; i < 4; i++) f[i] = (q[i].size() == DEPTH);
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) q[i].delete();
        m_valid = 0; m_data = '0; m_ch = 0; m_err = 0;
        m_req1 = 0; m_req2 = 0; m_gprev = 4'b0;
    endtask

    task automatic tick();
        logic [3:0] rq;
        logic [3:0] fl;
        int ng;
        rq = m_req();
        fl = m_full();
        ng = $countones(grant);
        @(posedge clk);
        m_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (ng == 1 && grant[i] && rq[i]) begin
                m_data  = q[i].pop_front();
                m_ch    = 2'(i);
                m_valid = 1;
            end
        end
        for (int i = 0; i < 4; i++)
            if (wr_en[i] && !fl[i]) q[i].push_back(wr_data[i*DW +: DW]);
`ifdef ARB_REQ_GRANT_CHECK_EN
        if (ng > 1 || (ng == 1 && grant != m_gprev && !m_req1 && !m_req2)) m_err = 1;
`endif
        m_req2  = m_req1;
        m_req1  = |rq;
        m_gprev = grant;
        #1;
    endtask

    task automatic idle();
        wr_en = 4'b0; wr_data = '0; grant = 4'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; wr_en = 4'hF; wr_data = $urandom; grant = 4'b0;
        #1;
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        checks++; if (req !== 4'b0) begin errors++; $display("FAIL reset_req: got %b expected 0000", req); end
        checks++; if (full !== 4'b0) begin errors++; $display("FAIL reset_full: got %b expected 0000", full); end
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== 2'd0) begin
            errors++; $display("FAIL reset_out: got v=%b d=%h ch=%0d expected 0/00/0", out_valid, out_data, out_ch); end
        checks++; if (grant_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", grant_err); end
        rst = 1'b1;
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        wr_en = 4'b1001; wr_data = $urandom;
        tick(); tick();
        idle();
        checks++; if (req !== m_req()) begin errors++; $display("FAIL prereset_req: got %b expected %b", req, m_req()); end
        do_reset();
    endtask

    task automatic test_single();
        int seen = 0;
        wr_en = 4'b0100; wr_data = '0; wr_data[2*DW +: DW] = 8'hA5;
        tick();
        wr_en = 4'b0;
        checks++; if (req !== 4'b0100) begin errors++; $display("FAIL single_req_rise: got %b expected 0100", req); end
        tick();
        grant = 4'b0100;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
            errors++; $display("FAIL single_out: got v=%b d=%h ch=%0d expected 1/a5/2", out_valid, out_data, out_ch); end
        checks++; if (req[2] !== 1'b0) begin errors++; $display("FAIL single_req_fall: got %b expected 0", req[2]); end
        for (int k = 0; k < 4; k++) begin tick(); if (out_valid === 1'b1) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL single_once: got %0d extra pops expected 0", seen); end
        checks++; if (grant_err !== m_err) begin errors++; $display("FAIL single_err: got %b expected %b", grant_err, m_err); end
        idle(); tick();
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 5; k++) begin
            wr_en = 4'b0001; wr_data = '0; wr_data[DW-1:0] = 8'h10 + 8'(k);
            tick();
            if (k == 3) begin
                checks++; if (full[0] !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full[0]); end
            end
        end
        wr_en = 4'b0; grant = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(k) || out_ch !== 2'd0) begin
                errors++; $display("FAIL ovf_drain%0d: got v=%b d=%h expected 1/%h", k, out_valid, out_data, 8'h10 + 8'(k)); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got v=%b d=%h expected no word", out_valid, out_data); end
        idle(); tick();
    endtask

    task automatic test_simul();
        logic [DW-1:0] last;
        for (int k = 0; k < 4; k++) begin
            wr_en = 4'b0010; wr_data = $urandom; tick();
        end
        grant = 4'b0010; wr_en = 4'b0010; wr_data = '0; wr_data[DW +: DW] = 8'h77;
        tick();
        wr_en = 4'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== m_data) begin
            errors++; $display("FAIL simfull_pop: got v=%b d=%h expected 1/%h", out_valid, out_data, m_data); end
        checks++; if (full[1] !== 1'b0 || req[1] !== 1'b1) begin
            errors++; $display("FAIL simfull_cnt: got full=%b req=%b expected 0/1", full[1], req[1]); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== m_valid || (m_valid && out_data !== m_data)) begin
                errors++; $display("FAIL simfull_drain%0d: got v=%b d=%h expected %b/%h", k, out_valid, out_data, m_valid, m_data); end
        end
        grant = 4'b0;
        for (int k = 0; k < 2; k++) begin wr_en = 4'b0010; wr_data = $urandom; tick(); end
        grant = 4'b0010; wr_en = 4'b0010; wr_data = '0; wr_data[DW +: DW] = 8'h77;
        tick();
        wr_en = 4'b0;
        checks++; if (req[1] !== 1'b1 || full[1] !== 1'b0) begin
            errors++; $display("FAIL simmid_cnt: got req=%b full=%b expected 1/0", req[1], full[1]); end
        last = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (out_valid === 1'b1) last = out_data;
        end
        checks++; if (last !== 8'h77) begin errors++; $display("FAIL simmid_last: got %h expected 77", last); end
        checks++; if (req[1] !== 1'b0) begin errors++; $display("FAIL simmid_empty: got %b expected 0", req[1]); end
        idle(); tick();
    endtask

    task automatic test_round_robin();
        wr_en = 4'hF; wr_data = $urandom;
        tick();
        wr_en = 4'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            grant = 4'b0001 << k;
            tick();
            checks++; if (out_valid !== 1'b1 || out_ch !== 2'(k) || out_data !== m_data) begin
                errors++; $display("FAIL rr_%0d: got v=%b ch=%0d d=%h expected 1/%0d/%h", k, out_valid, out_ch, out_data, k, m_data); end
        end
        idle(); tick();
    endtask

    task automatic test_bad_grant();
        logic exp_err;
`ifdef ARB_REQ_GRANT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        wr_en = 4'b0011; wr_data = $urandom;
        tick();
        wr_en = 4'b0;
        tick();
        grant = 4'b0011;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bad_nopop: got v=%b expected 0", out_valid); end
        checks++; if (req !== 4'b0011) begin errors++; $display("FAIL bad_req: got %b expected 0011", req); end
        checks++; if (grant_err !== exp_err) begin errors++; $display("FAIL bad_err: got %b expected %b", grant_err, exp_err); end
        grant = 4'b0;
        tick(); tick(); tick();
        checks++; if (grant_err !== exp_err) begin errors++; $display("FAIL bad_sticky: got %b expected %b", grant_err, exp_err); end
        do_reset();
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            wr_en = 4'($urandom);
            wr_data = $urandom;
            r = $urandom_range(0, 15);
            if (r < 3)       grant = 4'b0;
            else if (r < 14) grant = 4'b0001 << $urandom_range(0, 3);
            else             grant = 4'($urandom);
            tick();
            checks++; if (out_valid !== m_valid || out_data !== m_data || out_ch !== m_ch) begin
                errors++; $display("FAIL rand_out@%0d: got %b/%h/%0d expected %b/%h/%0d", c, out_valid, out_data, out_ch, m_valid, m_data, m_ch); end
            checks++; if (req !== m_req() || full !== m_full()) begin
                errors++; $display("FAIL rand_flags@%0d: got req=%b full=%b expected %b/%b", c, req, full, m_req(), m_full()); end
            checks++; if (grant_err !== m_err) begin
                errors++; $display("FAIL rand_err@%0d: got %b expected %b", c, grant_err, m_err); end
        end
        idle(); tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_clear();
        test_reset();
        test_single();
        test_overflow();
        test_simul();
        test_round_robin();
        test_bad_grant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
